// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared types, defaults and helpers for the systolic feeder
package sa_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      PLAY  = 2'd2,
      FLUSH = 2'd3
   } sa_state_e;

   localparam int SA_N      = 3;
   localparam int SA_IN_LEN = 8;
   localparam int SA_K_MAX  = 16;

   // Cycles between the final cal_done leaving row 0 and the last PE result.
   function automatic int flush_len(input int n);
      return 2 * n - 1;
   endfunction

endpackage

// File: rtl/sa_skew_line.sv
// rtl/sa_skew_line.sv - fixed-depth zero-reset delay line, depth 0 is a wire
module sa_skew_line #(
   parameter int D = 1,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   generate
      if (D == 0) begin : g_wire
         logic unused_d0;
         assign unused_d0 = clk ^ rst;
         assign q_o = d_i;
      end else begin : g_shift
         logic [W-1:0] sr_q [D];

         // Shift the word one stage per cycle; reset empties every stage.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int s = 0; s < D; s++) sr_q[s] <= '0;
            end else begin
               sr_q[0] <= d_i;
               for (int s = 1; s < D; s++) sr_q[s] <= sr_q[s-1];
            end
         end

         assign q_o = sr_q[D-1];
      end
   endgenerate

endmodule

// File: rtl/sa_feeder.sv
// rtl/sa_feeder.sv - burst buffer and skewed replay front-end for the systolic array
module sa_feeder
   import sa_pkg::*;
#(
   parameter int N      = SA_N,
   parameter int IN_LEN = SA_IN_LEN,
   parameter int K_MAX  = SA_K_MAX
) (
   input  logic                clk,
   input  logic                sys_rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                in_last,
   input  logic [N*IN_LEN-1:0] a_vec,
   input  logic [N*IN_LEN-1:0] b_vec,
   output logic [N*IN_LEN-1:0] west_data,
   output logic [N*IN_LEN-1:0] north_data,
   output logic [N-1:0]        row_cal_en,
   output logic [N-1:0]        row_cal_done,
   output logic                busy,
   output logic                done,
   output logic                err_len
);

   localparam int CW = $clog2(K_MAX + 1);
   localparam int AW = (K_MAX > 1) ? $clog2(K_MAX) : 1;
   localparam int VW = N * IN_LEN;
   localparam logic [CW-1:0] LAST_SLOT = CW'(K_MAX - 1);
   localparam logic [CW-1:0] FLUSH_CNT = CW'(flush_len(N));

   sa_state_e     state_q, state_d;
   logic [CW-1:0] wr_q, wr_d;
   logic [CW-1:0] len_q, len_d;
   logic [CW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          st_en_q, st_en_d;
   logic          st_done_q, st_done_d;
   logic [VW-1:0] st_a_q, st_a_d;
   logic [VW-1:0] st_b_q, st_b_d;

   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          busy_q, rdy_q;

   logic          accept;
   logic          mem_we;
   logic [VW-1:0] a_mem_q [K_MAX];
   logic [VW-1:0] b_mem_q [K_MAX];

   assign accept = in_valid && rdy_q;

   // Operand buffer; contents are only meaningful below len_q, so no reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         a_mem_q[wr_q[AW-1:0]] <= a_vec;
         b_mem_q[wr_q[AW-1:0]] <= b_vec;
      end
   end

   // Next-state, buffer write and replay stage selection.
   always_comb begin
      state_d   = state_q;
      wr_d      = wr_q;
      len_d     = len_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      mem_we    = 1'b0;
      st_en_d   = 1'b0;
      st_done_d = 1'b0;
      st_a_d    = '0;
      st_b_d    = '0;
      done_d    = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE, LOAD: begin
            if (accept) begin
               mem_we = 1'b1;
               if (in_last || wr_q == LAST_SLOT) begin
                  // Overflow without in_last: truncate; later beats start a new burst.
                  len_d   = wr_q + 1'b1;
                  wr_d    = '0;
                  rd_d    = '0;
                  err_d   = !in_last;
                  state_d = PLAY;
               end else begin
                  wr_d    = wr_q + 1'b1;
                  state_d = LOAD;
               end
            end
         end
         PLAY: begin
            if (rd_q < len_q) begin
               st_en_d = 1'b1;
               st_a_d  = a_mem_q[rd_q[AW-1:0]];
               st_b_d  = b_mem_q[rd_q[AW-1:0]];
               rd_d    = rd_q + 1'b1;
            end else begin
               st_done_d = 1'b1;
               cnt_d     = FLUSH_CNT;
               state_d   = FLUSH;
            end
         end
         FLUSH: begin
            // done lands one cycle before IDLE so busy drops the cycle after it.
            if (cnt_q == CW'(1)) done_d = 1'b1;
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, counters, replay stage and registered status outputs.
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q   <= IDLE;
         wr_q      <= '0;
         len_q     <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
         st_en_q   <= 1'b0;
         st_done_q <= 1'b0;
         st_a_q    <= '0;
         st_b_q    <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         rdy_q     <= 1'b1;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         len_q     <= len_d;
         rd_q      <= rd_d;
         cnt_q     <= cnt_d;
         st_en_q   <= st_en_d;
         st_done_q <= st_done_d;
         st_a_q    <= st_a_d;
         st_b_q    <= st_b_d;
         done_q    <= done_d;
         err_q     <= err_d;
         busy_q    <= (state_d != IDLE);
         rdy_q     <= (state_d == IDLE) || (state_d == LOAD);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_row
         logic [IN_LEN+1:0] row_d, row_q;
         assign row_d = {st_done_q, st_en_q, st_a_q[gi*IN_LEN +: IN_LEN]};

         sa_skew_line #(.D(gi), .W(IN_LEN + 2)) u_row_skew (
            .clk (clk),
            .rst (sys_rst),
            .d_i (row_d),
            .q_o (row_q)
         );

         assign row_cal_done[gi]               = row_q[IN_LEN+1];
         assign row_cal_en[gi]                 = row_q[IN_LEN];
         assign west_data[gi*IN_LEN +: IN_LEN] = row_q[IN_LEN-1:0];
      end

      for (gi = 0; gi < N; gi++) begin : g_col
         sa_skew_line #(.D(gi), .W(IN_LEN)) u_col_skew (
            .clk (clk),
            .rst (sys_rst),
            .d_i (st_b_q[gi*IN_LEN +: IN_LEN]),
            .q_o (north_data[gi*IN_LEN +: IN_LEN])
         );
      end
   endgenerate

   assign in_ready = rdy_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err_len  = err_q;

endmodule

// File: tb/tb_sa_feeder.sv
// tb/tb_sa_feeder.sv - directed table-driven bench for sa_feeder
module tb_sa_feeder;

   localparam int N  = 3;
   localparam int L  = 8;
   localparam int KM = 16;
   localparam int OW = 2 * N * L + 2 * N + 4;

   logic           clk = 1'b0;
   logic           sys_rst;
   logic           in_valid, in_ready, in_last;
   logic [N*L-1:0] a_vec, b_vec, west_data, north_data;
   logic [N-1:0]   row_cal_en, row_cal_done;
   logic           busy, done, err_len;

   sa_feeder #(.N(N), .IN_LEN(L), .K_MAX(KM)) dut (
      .clk          (clk),
      .sys_rst      (sys_rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_last      (in_last),
      .a_vec        (a_vec),
      .b_vec        (b_vec),
      .west_data    (west_data),
      .north_data   (north_data),
      .row_cal_en   (row_cal_en),
      .row_cal_done (row_cal_done),
      .busy         (busy),
      .done         (done),
      .err_len      (err_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      int k;
      int gap;
      int mode;
      int done_t;
   } vec_t;

   vec_t           tbl [5];
   logic [N*L-1:0] va [KM];
   logic [N*L-1:0] vb [KM];
   int             n_chk = 0;
   int             n_pass = 0;

   function automatic logic [OW-1:0] pack_out();
      return {west_data, north_data, row_cal_en, row_cal_done, done, busy, in_ready, err_len};
   endfunction

   function automatic logic [OW-1:0] idle_exp(input bit bsy, input bit rdy);
      logic [OW-1:0] e;
      e = '0;
      e[2] = bsy;
      e[1] = rdy;
      return e;
   endfunction

   // Expected outputs at cycle t relative to P for a burst of k beats.
   function automatic logic [OW-1:0] play_exp(input int t, input int k, input int done_t, input bit err);
      logic [N*L-1:0] w, nd, vv;
      logic [N-1:0]   en, cd;
      w = '0; nd = '0; en = '0; cd = '0;
      for (int i = 0; i < N; i++) begin
         if (t >= i && t < i + k) begin
            en[i] = 1'b1;
            vv = va[t-i];
            w[i*L +: L] = vv[i*L +: L];
            vv = vb[t-i];
            nd[i*L +: L] = vv[i*L +: L];
         end
         if (t == i + k) cd[i] = 1'b1;
      end
      return {w, nd, en, cd, (t == done_t), (t <= done_t), (t == done_t + 1), (err && t == -1)};
   endfunction

   task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fill(input int mode, input int k);
      for (int kk = 0; kk < k; kk++) begin
         for (int e = 0; e < N; e++) begin
            case (mode)
               2:       begin va[kk][e*L +: L] = 8'(e + 1); vb[kk][e*L +: L] = 8'(e + 4); end
               1:       begin va[kk][e*L +: L] = (e == kk) ? 8'd1 : 8'd0; vb[kk][e*L +: L] = 8'(kk * 3 + e + 1); end
               default: begin va[kk][e*L +: L] = 8'($urandom_range(255)); vb[kk][e*L +: L] = 8'($urandom_range(255)); end
            endcase
         end
      end
   endtask

   // Drive k beats from va/vb with idle gaps between them; leaves the bench in cycle P-1.
   task automatic load_burst(input int k, input int gap, input bit last_on_final);
      for (int b = 0; b < k; b++) begin
         if (b > 0) repeat (gap) begin in_valid = 1'b0; step(); end
         in_valid = 1'b1;
         a_vec    = va[b];
         b_vec    = vb[b];
         in_last  = last_on_final && (b == k - 1);
         begin
            int w;
            w = 0;
            while (!in_ready && w < 50) begin step(); w++; end
            if (w == 50) $display("FAIL load_timeout: beat %0d never accepted", b);
         end
         chk($sformatf("load_beat%0d", b), pack_out(), idle_exp(b > 0, 1'b1));
         step();
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   // Compare every cycle from P-1 through the in_ready-rise cycle.
   task automatic check_play(input string name, input int k, input int done_t, input bit err);
      for (int t = -1; t <= done_t + 1; t++) begin
         chk($sformatf("%s_t%0d", name, t), pack_out(), play_exp(t, k, done_t, err));
         if (t <= done_t) step();
      end
   endtask

   logic [N*L-1:0] held_a, held_b;

   initial begin
      tbl[0] = '{k: 1,  gap: 0, mode: 2, done_t: 6};
      tbl[1] = '{k: 4,  gap: 2, mode: 1, done_t: 9};
      tbl[2] = '{k: 3,  gap: 1, mode: 0, done_t: 8};
      tbl[3] = '{k: 2,  gap: 0, mode: 0, done_t: 7};
      tbl[4] = '{k: 16, gap: 0, mode: 0, done_t: 21};

      sys_rst  = 1'b1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      a_vec    = '0;
      b_vec    = '0;
      repeat (2) step();
      chk("reset_state", pack_out(), idle_exp(1'b0, 1'b1));
      sys_rst = 1'b0;
      step();
      chk("after_reset", pack_out(), idle_exp(1'b0, 1'b1));

      for (int v = 0; v < 5; v++) begin
         fill(tbl[v].mode, tbl[v].k);
         load_burst(tbl[v].k, tbl[v].gap, 1'b1);
         check_play($sformatf("vec%0d", v), tbl[v].k, tbl[v].done_t, 1'b0);
      end

      // 17 beats, in_last only on the 17th: truncation at 16, 17th held through PLAY/FLUSH.
      fill(0, KM);
      held_a = 24'h0a0b0c;
      held_b = 24'h0d0e0f;
      load_burst(KM, 0, 1'b0);
      in_valid = 1'b1;
      in_last  = 1'b1;
      a_vec    = held_a;
      b_vec    = held_b;
      check_play("ovf16", KM, 21, 1'b1);
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      va[0] = held_a;
      vb[0] = held_b;
      check_play("ovf_k1", 1, 6, 1'b0);

      // Reset asserted at P+2 of a K=4 burst.
      fill(0, 4);
      load_burst(4, 0, 1'b1);
      for (int t = -1; t <= 2; t++) begin
         chk($sformatf("pre_rst_t%0d", t), pack_out(), play_exp(t, 4, 9, 1'b0));
         if (t < 2) step();
      end
      sys_rst = 1'b1;
      step();
      chk("mid_reset", pack_out(), idle_exp(1'b0, 1'b1));
      sys_rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         chk($sformatf("post_rst_c%0d", c), pack_out(), idle_exp(1'b0, 1'b1));
      end
      fill(2, 1);
      load_burst(1, 0, 1'b1);
      check_play("after_rst_k1", 1, 6, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/sa_feeder.md
# sa_feeder

Front-end stage of the N×N systolic matrix-multiply array built from `PE_MAC` cells. It buffers one burst of K operand vectors: row-vector A columns and column-vector B rows. It then replays the burst contiguously with the diagonal skew the array needs. It also generates the per-row `cal_en`/`cal_done` strobes that the PEs propagate eastward. The array has no stall path, so this block absorbs all upstream back-pressure and gaps.

## Interface
- `N`, 3, array dimension (rows = columns).
- `IN_LEN`, 8, operand width per element.
- `K_MAX`, 16, maximum burst length (inner-product depth).
- `clk`  in  1  sole clock. One clock; reset is asynchronous and active-high.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  upstream beat valid.
- `in_ready`  out  1  block can accept a beat.
- `in_last`  in  1  final beat of the burst.
- `a_vec`  in  N*IN_LEN  element i = A[i][k] (row i, depth k); element i at bits [i*IN_LEN +: IN_LEN].
- `b_vec`  in  N*IN_LEN  element j = B[k][j].
- `west_data`  out  N*IN_LEN  to `westin` of PE(i,0), per row i.
- `north_data`  out  N*IN_LEN  to `northin` of PE(0,j), per column j.
- `row_cal_en`  out  N  to `cal_en` of PE(i,0).
- `row_cal_done`  out  N  to `cal_done` of PE(i,0).
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when the last PE result is valid.
- `err_len`  out  1  one-cycle pulse on forced burst truncation.

## Operation
- FSM states: IDLE, LOAD, PLAY, FLUSH.
- IDLE:
  - `in_ready`=1.
  - An accepted beat is written to slot 0.
  - Next state is LOAD, or PLAY if `in_last` is set on that beat.
- LOAD:
  - `in_ready`=1.
  - Each accepted beat is written to slot k, and k increments.
  - A beat with `in_last`, or the beat at slot K_MAX-1, ends the load. K = slots written, and the FSM goes to PLAY.
  - If the K_MAX-1 beat lacks `in_last`, pulse `err_len`. Beats arriving after that belong to the next burst.
  - Gaps in `in_valid` are allowed and have no effect on the array.
- PLAY:
  - `in_ready`=0.
  - Read slot 0..K-1 on K consecutive cycles with no bubbles.
  - Then issue one `cal_done` cycle.
  - Then go to FLUSH.
- FLUSH:
  - `in_ready`=0.
  - Count down until the last skewed strobe has left the block and the array result is out.
  - Pulse `done` and return to IDLE.
- Skew rules:
  - Row i data, `row_cal_en[i]` and `row_cal_done[i]` are delayed by i cycles.
  - Column j data is delayed by j cycles.
  - Row 0 and column 0 have zero added delay beyond the output register.
- Zero-fill: every `west_data`/`north_data` element is 0 whenever its row's or column's skewed enable is low.
- Arithmetic: none. Widths are passed through. Counters are $clog2(K_MAX+1) bits.
- Reset mid-operation: FSM returns to IDLE, delay lines and outputs clear, and the buffer contents are discarded. The array then sees `cal_en`=0, which clears its partial sums.

## Timing
- All outputs are registered.
- Reset values: `in_ready`=1, and every other output is 0.
- Let P be the first cycle in which `row_cal_en[0]`=1 at the output. P is 1 cycle after the FSM enters PLAY.
- Row i:
  - `row_cal_en[i]`=1 during cycles P+i .. P+i+K-1.
  - `west_data` element i = A[i][k] at cycle P+i+k.
  - `row_cal_done[i]`=1 only at cycle P+i+K, with `row_cal_en[i]`=0.
- Column j: `north_data` element j = B[k][j] at cycle P+j+k.
- PE(i,j) result is valid at P+i+j+K+1.
- `done` pulses at P+K+2N-1.
- `busy` falls the cycle after `done`, and `in_ready` rises the same cycle.
- A minimum-gap back-to-back burst starts accepting in that cycle.
- Strobes from consecutive bursts never overlap in any row.

## Structure
- Shared package `sa_pkg`:
  - FSM state enum (IDLE/LOAD/PLAY/FLUSH).
  - Default constants for N, IN_LEN and K_MAX.
  - A function for the flush length 2N-1.
- Sub-module `sa_skew_line`:
  - Parameterised depth D and width W; D=0 means a wire.
  - Zeroed on reset.
  - Instantiated per row (data + en + done) and per column (data).
- Operand buffer: two K_MAX×(N*IN_LEN) register arrays, one each for A and B.

## Test plan
- N=3, K=1, A=[1,2,3], B=[4,5,6], one beat with `in_last`:
  - `row_cal_en[2]` high only at P+2.
  - `west_data` row 2 = 3 at P+2.
  - `done` at P+6.
- K=4, 3×3 identity A and B=1..12, with `in_valid` gaps of 2 cycles during LOAD:
  - `row_cal_en` is contiguous for 4 cycles in every row.
  - Array douts equal B.
- Beats presented during PLAY and FLUSH: `in_ready`=0 and no beat is consumed. The held beat is accepted in the cycle after `done`.
- K_MAX+1=17 beats with `in_last` only on beat 17:
  - `err_len` pulses on beat 16 and K=16 plays.
  - Beat 17 starts a new burst of K=1.
- `sys_rst` asserted at P+2 with K=4: all outputs 0 the next cycle, FSM in IDLE, `in_ready`=1, no `done`.
- Zero-fill check: random bursts; whenever `row_cal_en[i]`=0, row i data is 0, and the matching check holds for columns.
